// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_pkg
// Description : Shared encodings for the iterative multiply/divide unit:
//               funct3 operation codes, FSM states, M-extension funct7 and
//               operand-signedness helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_unit_pkg;

    // funct3 operation encodings (RV32M)
    localparam logic [2:0] MULDIV_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_REM    = 3'b110;
    localparam logic [2:0] MULDIV_REMU   = 3'b111;

    // funct7 value that selects the M extension in the control unit decode
    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    // FSM state encodings
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // rs1 is interpreted as signed by MUL, MULH, MULHSU, DIV and REM
    function automatic logic a_is_signed(input logic [2:0] f);
        return (f != MULDIV_MULHU) && (f != MULDIV_DIVU) && (f != MULDIV_REMU);
    endfunction

    // rs2 is interpreted as signed by MUL, MULH, DIV and REM
    function automatic logic b_is_signed(input logic [2:0] f);
        return (f == MULDIV_MUL) || (f == MULDIV_MULH) ||
               (f == MULDIV_DIV) || (f == MULDIV_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_if
// Description : Request/response bundle between the EX stage and the
//               multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
    parameter int XLEN = 32
) ();
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    // Requester side (pipeline EX stage)
    modport master (
        output start, funct3, op_a, op_b, flush,
        input  busy, done, result
    );

    // Unit side
    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit_operand_prep.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_operand_prep
// Description : Combinational operand conditioning: magnitudes, effective
//               sign flags and divide-by-zero / signed-overflow detection.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_operand_prep
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic [XLEN-1:0] o_mag_a,
    output logic [XLEN-1:0] o_mag_b,
    output logic            o_neg_a,
    output logic            o_neg_b,
    output logic            o_div_zero,
    output logic            o_sgn_ovf
);

    localparam logic [XLEN-1:0] C_MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // Sign flags are only set for operands the op treats as signed, so the
    // magnitude of the most negative value wraps to itself (correct unsigned)
    always_comb begin
        o_neg_a    = a_is_signed(i_funct3) & i_op_a[XLEN-1];
        o_neg_b    = b_is_signed(i_funct3) & i_op_b[XLEN-1];
        o_mag_a    = o_neg_a ? -i_op_a : i_op_a;
        o_mag_b    = o_neg_b ? -i_op_b : i_op_b;
        o_div_zero = i_funct3[2] & (i_op_b == '0);
        o_sgn_ovf  = ((i_funct3 == MULDIV_DIV) || (i_funct3 == MULDIV_REM)) &
                     (i_op_a == C_MOST_NEG) & (i_op_b == '1);
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative radix-2 multiply (shift/add) and restoring divide
//               unit for RV32M-style ops. One iteration per cycle, XLEN
//               iterations per op, registered result with a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);

    localparam int            CW     = $clog2(XLEN);
    localparam logic [CW-1:0] C_LAST = CW'(XLEN - 1);

    // Operand conditioning
    logic [XLEN-1:0] w_mag_a, w_mag_b;
    logic            w_neg_a, w_neg_b, w_div_zero, w_sgn_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_val;

    muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
        .i_funct3   (bus.funct3),
        .i_op_a     (bus.op_a),
        .i_op_b     (bus.op_b),
        .o_mag_a    (w_mag_a),
        .o_mag_b    (w_mag_b),
        .o_neg_a    (w_neg_a),
        .o_neg_b    (w_neg_b),
        .o_div_zero (w_div_zero),
        .o_sgn_ovf  (w_sgn_ovf)
    );

    // State registers
    md_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;     // product or {remainder, quotient}
    logic [XLEN-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic [2:0]        op_q, op_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic              spec_q, spec_d;
    logic [XLEN-1:0]   spec_val_q, spec_val_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Datapath wires
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_div_top;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_div_rem;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_step;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_fixed, w_final;

    // RISC-V mandated results for divide-by-zero and signed overflow
    always_comb begin
        w_special     = w_div_zero | w_sgn_ovf;
        w_special_val = '0;
        if (w_div_zero) begin
            w_special_val = bus.funct3[1] ? bus.op_a : '1;
        end else if (w_sgn_ovf) begin
            w_special_val = bus.funct3[1] ? '0 : bus.op_a;
        end
    end

    // One iteration: multiply adds the multiplicand on the low product bit and
    // shifts right; divide shifts left and subtracts when the divisor fits.
    // The divide compare uses XLEN+1 bits because the shifted partial
    // remainder can exceed XLEN bits for large divisors.
    always_comb begin
        w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        w_mul_next = {w_mul_sum, acc_q[XLEN-1:1]};
        w_div_top  = acc_q[2*XLEN-1:XLEN-1];
        w_div_ge   = (w_div_top >= {1'b0, opnd_q});
        w_div_rem  = w_div_top[XLEN-1:0] - opnd_q;
        w_div_next = w_div_ge ? {w_div_rem, acc_q[XLEN-2:0], 1'b1}
                              : {acc_q[2*XLEN-2:0], 1'b0};
        w_step     = op_q[2] ? w_div_next : w_mul_next;
    end

    // Sign correction of the final iteration's value
    always_comb begin
        w_prod  = (neg_a_q ^ neg_b_q) ? -w_step : w_step;
        w_quo   = (neg_a_q ^ neg_b_q) ? -w_step[XLEN-1:0] : w_step[XLEN-1:0];
        w_rem   = neg_a_q ? -w_step[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];
        case (op_q)
            MULDIV_MUL:                w_fixed = w_prod[XLEN-1:0];
            MULDIV_DIV, MULDIV_DIVU:   w_fixed = w_quo;
            MULDIV_REM, MULDIV_REMU:   w_fixed = w_rem;
            default:                   w_fixed = w_prod[2*XLEN-1:XLEN];
        endcase
        w_final = spec_q ? spec_val_q : w_fixed;
    end

    // FSM next-state: accept in IDLE/DONE, iterate in CALC, flush overrides all
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        op_d       = op_q;
        neg_a_d    = neg_a_q;
        neg_b_d    = neg_b_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        result_d   = result_q;
        done_d     = 1'b0;
        if (bus.flush) begin
            state_d = MD_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                MD_CALC: begin
                    acc_d = w_step;
                    if (cnt_q == C_LAST) begin
                        cnt_d    = '0;
                        state_d  = MD_DONE;
                        done_d   = 1'b1;
                        result_d = w_final;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = MD_IDLE;
                    if (bus.start) begin
                        op_d       = bus.funct3;
                        neg_a_d    = w_neg_a;
                        neg_b_d    = w_neg_b;
                        spec_d     = w_special;
                        spec_val_d = w_special_val;
                        cnt_d      = '0;
                        opnd_d     = bus.funct3[2] ? w_mag_b : w_mag_a;
                        acc_d      = {{XLEN{1'b0}}, (bus.funct3[2] ? w_mag_a : w_mag_b)};
                        if (EARLY_OUT && w_special) begin
                            state_d  = MD_DONE;
                            done_d   = 1'b1;
                            result_d = w_special_val;
                        end else begin
                            state_d  = MD_CALC;
                        end
                    end
                end
            endcase
        end
        busy_d = (state_d == MD_CALC);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MD_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            op_q       <= '0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            op_q       <= op_d;
            neg_a_q    <= neg_a_d;
            neg_b_q    <= neg_b_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule
`default_nettype wire
